serial_bus_arbiter: RTL

//  Shares the virtual serial slave between two bus requesters (p0 = CPU data port, p1 = debug/boot loader).

---
 rtl/serial_arb_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 48 ++++
 rtl/serial_bus_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg
//   Shared types and constants for the two-requester serial bus arbiter:
//   FSM state encoding, requester ids, default timeout, the debug struct
//   exposed by the top level, and a saturating increment for the timeout
//   counter.
package serial_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic OWNER_P0 = 1'b0;
   localparam logic OWNER_P1 = 1'b1;

   localparam int unsigned TIMEOUT_DEFAULT = 15;
   localparam int unsigned CNT_W           = 8;

   // Observation port: FSM state, round-robin pointer (id served last)
   // and the ISSUE+WAIT cycle counter.
   typedef struct packed {
      state_e           state;
      logic             rr_ptr;
      logic [CNT_W-1:0] cnt;
   } dbg_t;

   // Counter saturates instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter. The pointer remembers the requester that
//   was served last; on a tie the other requester wins. The pointer only
//   moves when grant_en_i is high and at least one request is present.
// Ports
//   clk_i       in   clock
//   rst_i       in   asynchronous active-high reset (pointer -> 1, so p0 wins first tie)
//   req_i[1:0]  in   request vector, bit n = requester n
//   grant_en_i  in   a grant is being taken this cycle
//   gnt_o[1:0]  out  one-hot grant (combinational, 0 when no request)
//   ptr_o       out  id of the requester served last
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       grant_en_i,
   output logic [1:0] gnt_o,
   output logic       ptr_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = req_i;
      // Tie: whoever was not served last wins.
      if (req_i == 2'b11) begin
         gnt_o = ptr_q ? 2'b01 : 2'b10;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en_i && (|req_i)) begin
         ptr_d = gnt_o[1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
//   Shares one serial slave between two requesters (p0 = CPU data port,
//   p1 = debug/boot loader). One transfer in flight: IDLE picks a winner
//   and latches its payload, ISSUE presents Hselect and strobes ready in
//   the single cycle the slave has Hready high, WAIT captures the read data
//   and response, RESP pulses the owner's done for one cycle. A saturating
//   counter bounds the time spent in ISSUE+WAIT; on expiry the transfer
//   completes with err=1 and rdata=0.
//
//   Handshake: the slave accepts the strobe in a cycle where ready=1 (which
//   implies Hready=1); the data phase completes in the first later cycle
//   with Hready=1. A requester holds pN_req until the cycle its pN_done is
//   high; its payload is sampled only in the grant cycle.
// Ports
//   Hclock, Hreset                  clock, asynchronous active-high reset
//   p0_*/p1_*                       requester req/write/addr/wdata in, done out
//   rdata, err                      completion data / error, valid with pN_done
//   Hselect, ready, Hwrite,
//   Haddress, Hwritedata, Hsize     slave request side
//   Hreaddata, Hready, Hresponse    slave response side
//   dbg                             state, round-robin pointer, counter
module serial_bus_arbiter
   import serial_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              Hclock,
   input  logic              Hreset,
   input  logic              p0_req,
   input  logic              p0_write,
   input  logic [2:0]        p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_done,
   input  logic              p1_req,
   input  logic              p1_write,
   input  logic [2:0]        p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              Hselect,
   output logic              ready,
   output logic              Hwrite,
   output logic [2:0]        Haddress,
   output logic [DATA_W-1:0] Hwritedata,
   output logic              Hsize,
   input  logic [DATA_W-1:0] Hreaddata,
   input  logic              Hready,
   input  logic              Hresponse,
   output dbg_t              dbg
);

   // Counter value seen in the last cycle allowed before timeout.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                write_q, write_d;
   logic [2:0]          addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [1:0]          gnt;
   logic                rr_ptr;
   logic                grant_en;
   logic                timeout_hit;

   assign grant_en    = (state_q == ST_IDLE);
   assign timeout_hit = (cnt_q >= TO_LAST);

   rr_arbiter2 u_rr (
      .clk_i      (Hclock),
      .rst_i      (Hreset),
      .req_i      ({p1_req, p0_req}),
      .grant_en_i (grant_en),
      .gnt_o      (gnt),
      .ptr_o      (rr_ptr)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               owner_d = gnt[1] ? OWNER_P1 : OWNER_P0;
               write_d = gnt[0] ? p0_write : p1_write;
               addr_d  = gnt[0] ? p0_addr  : p1_addr;
               wdata_d = gnt[0] ? p0_wdata : p1_wdata;
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // An accepted strobe wins over a timeout in the same cycle.
            if (Hready) begin
               cnt_d   = sat_inc(cnt_q);
               state_d = ST_WAIT;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_WAIT: begin
            if (Hready) begin
               rdata_d = Hreaddata;
               err_d   = Hresponse;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Hclock or posedge Hreset) begin
      if (Hreset) begin
         state_q <= ST_IDLE;
         owner_q <= OWNER_P0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Slave side: payload straight from the latch so it never toggles
   // outside ISSUE; the strobe is the only term that looks at Hready.
   assign Hselect    = (state_q == ST_ISSUE);
   assign ready      = Hselect & Hready;
   assign Hwrite     = write_q;
   assign Haddress   = addr_q;
   assign Hwritedata = wdata_q;
   assign Hsize      = 1'b0;

   // Requester side: err is only meaningful alongside a done pulse.
   assign p0_done = (state_q == ST_RESP) && (owner_q == OWNER_P0);
   assign p1_done = (state_q == ST_RESP) && (owner_q == OWNER_P1);
   assign rdata   = rdata_q;
   assign err     = err_q && (state_q == ST_RESP);

   assign dbg = '{state: state_q, rr_ptr: rr_ptr, cnt: cnt_q};

endmodule
